// File: rtl/mnist_argmax_fix14.sv
// Argmax classifier over the inference engine's logit mux: scans NUM_CLASSES signed logits
// after a dnn_done rising edge and holds the winning class. MNIST_ARGMAX_MARGIN_EN adds margin.
module mnist_argmax_fix14 #(
    parameter int unsigned DATA_WIDTH  = 14,
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned IDX_WIDTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dnn_done,
    input  logic                         clear,
    output logic [IDX_WIDTH-1:0]         out_idx,
    input  logic signed [DATA_WIDTH-1:0] out,
    output logic                         busy,
    output logic                         class_valid,
    output logic [IDX_WIDTH-1:0]         class_idx,
    output logic signed [DATA_WIDTH-1:0] max_score
`ifdef MNIST_ARGMAX_MARGIN_EN
    ,
    output logic [DATA_WIDTH:0]          margin
`endif
);

    typedef enum logic [1:0] {StIdle, StScan, StHold} state_e;

    localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_CLASSES - 1);

    state_e                         state_q, state_d;
    logic                           done_q;
    logic [IDX_WIDTH-1:0]           idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0]   best_q, best_d;
    logic [IDX_WIDTH-1:0]           best_idx_q, best_idx_d;
    logic [IDX_WIDTH-1:0]           class_idx_q, class_idx_d;
    logic signed [DATA_WIDTH-1:0]   max_score_q, max_score_d;
    logic signed [DATA_WIDTH-1:0]   cur_best;
    logic [IDX_WIDTH-1:0]           cur_best_idx;
    logic                           start;
`ifdef MNIST_ARGMAX_MARGIN_EN
    localparam logic signed [DATA_WIDTH-1:0] MinVal = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    logic signed [DATA_WIDTH-1:0]   second_q, second_d;
    logic signed [DATA_WIDTH-1:0]   cur_second;
    logic [DATA_WIDTH:0]            margin_q, margin_d;
`endif

    always_comb begin
        start        = dnn_done && !done_q;
        state_d      = state_q;
        idx_d        = idx_q;
        best_d       = best_q;
        best_idx_d   = best_idx_q;
        class_idx_d  = class_idx_q;
        max_score_d  = max_score_q;
        cur_best     = best_q;
        cur_best_idx = best_idx_q;
`ifdef MNIST_ARGMAX_MARGIN_EN
        second_d     = second_q;
        margin_d     = margin_q;
        cur_second   = second_q;
`endif

        // Running max including the logit presented this cycle; strict > keeps the lowest index.
        if (idx_q == '0) begin
            cur_best     = out;
            cur_best_idx = '0;
`ifdef MNIST_ARGMAX_MARGIN_EN
            cur_second   = MinVal;
`endif
        end else if (out > best_q) begin
`ifdef MNIST_ARGMAX_MARGIN_EN
            cur_second   = best_q;
`endif
            cur_best     = out;
            cur_best_idx = idx_q;
        end
`ifdef MNIST_ARGMAX_MARGIN_EN
        else if (out > second_q) begin
            cur_second = out;
        end
`endif

        case (state_q)
            StIdle, StHold: begin
                idx_d = '0;
                if (start) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                best_d     = cur_best;
                best_idx_d = cur_best_idx;
`ifdef MNIST_ARGMAX_MARGIN_EN
                second_d   = cur_second;
`endif
                if (idx_q == LastIdx) begin
                    state_d     = StHold;
                    idx_d       = '0;
                    class_idx_d = cur_best_idx;
                    max_score_d = cur_best;
`ifdef MNIST_ARGMAX_MARGIN_EN
                    // Best >= second, so the widened difference is never negative.
                    margin_d    = {cur_best[DATA_WIDTH-1], cur_best}
                                - {cur_second[DATA_WIDTH-1], cur_second};
`endif
                end else begin
                    idx_d = idx_q + IDX_WIDTH'(1);
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase

        if (clear) begin
            state_d     = StIdle;
            idx_d       = '0;
            class_idx_d = '0;
            max_score_d = '0;
`ifdef MNIST_ARGMAX_MARGIN_EN
            margin_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            done_q      <= 1'b0;
            idx_q       <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            class_idx_q <= '0;
            max_score_q <= '0;
`ifdef MNIST_ARGMAX_MARGIN_EN
            second_q    <= '0;
            margin_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            done_q      <= dnn_done;
            idx_q       <= idx_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            class_idx_q <= class_idx_d;
            max_score_q <= max_score_d;
`ifdef MNIST_ARGMAX_MARGIN_EN
            second_q    <= second_d;
            margin_q    <= margin_d;
`endif
        end
    end

    assign out_idx     = idx_q;
    assign busy        = (state_q == StScan);
    assign class_valid = (state_q == StHold);
    assign class_idx   = class_idx_q;
    assign max_score   = max_score_q;
`ifdef MNIST_ARGMAX_MARGIN_EN
    assign margin      = margin_q;
`endif

endmodule

// File: tb/tb_mnist_argmax_fix14.sv
// Self-checking bench for mnist_argmax_fix14: table-driven scans with a result scoreboard,
// plus sequences for held dnn_done, mid-scan reset and clear colliding with a start.
module tb_mnist_argmax_fix14;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              dnn_done = 1'b0;
    logic              clear = 1'b0;
    logic [3:0]        out_idx;
    logic signed [13:0] out_s;
    logic              busy;
    logic              class_valid;
    logic [3:0]        class_idx;
    logic signed [13:0] max_score;
`ifdef MNIST_ARGMAX_MARGIN_EN
    logic [14:0]       margin;
`endif

    int logits[10];
    int checks = 0;
    int failures = 0;

    typedef struct {
        string name;
        int    l[10];
        int    exp_idx;
        int    exp_score;
        int    exp_margin;
    } vec_t;

    typedef struct {
        string name;
        int    idx;
        int    score;
        int    margin;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];

    mnist_argmax_fix14 dut (
        .clk         (clk),
        .rst         (rst),
        .dnn_done    (dnn_done),
        .clear       (clear),
        .out_idx     (out_idx),
        .out         (out_s),
        .busy        (busy),
        .class_valid (class_valid),
        .class_idx   (class_idx),
        .max_score   (max_score)
`ifdef MNIST_ARGMAX_MARGIN_EN
        ,
        .margin      (margin)
`endif
    );

    always #5 clk = ~clk;

    // Engine logit mux model: purely combinational from out_idx.
    always_comb begin
        out_s = '0;
        if (out_idx < 4'd10) out_s = 14'(logits[out_idx]);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_result(input exp_t e);
        check({e.name, " class_idx"}, int'(class_idx), e.idx);
        check({e.name, " max_score"}, int'(max_score), e.score);
`ifdef MNIST_ARGMAX_MARGIN_EN
        check({e.name, " margin"}, int'(margin), e.margin);
`endif
    endtask

    // Pulse dnn_done, follow the scan, then pop and compare the scoreboard entry.
    task automatic run_scan(input vec_t v);
        exp_t e;
        int   n;
        bit   got;
        bit   seq_ok;
        logits = v.l;
        e.name = v.name; e.idx = v.exp_idx; e.score = v.exp_score; e.margin = v.exp_margin;
        sb.push_back(e);
        @(negedge clk);
        dnn_done = 1'b1;
        n = 0; got = 1'b0; seq_ok = 1'b1;
        for (int c = 1; c <= 30 && !got; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) dnn_done = 1'b0;
            if (class_valid) begin
                got = 1'b1;
                n = c;
            end else if (!busy || int'(out_idx) != c - 1) begin
                seq_ok = 1'b0;
            end
        end
        check({v.name, " latency"}, n, 11);
        check({v.name, " scan sequence ok"}, int'(seq_ok), 1);
        check({v.name, " busy after scan"}, int'(busy), 0);
        if (sb.size() > 0) compare_result(sb.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int  busy_cycles;
        int  valid_rises;
        bit  prev_valid;
        bit  seen;

        vecs[0] = '{"basic", '{-5, 3, 1, 0, 2, 9, 4, -1, 8, 6}, 5, 9, 1};
        vecs[1] = '{"tie", '{1, 2, 7, 3, 0, 7, -4, 6, 5, -1}, 2, 7, 0};
        vecs[2] = '{"allneg", '{-8192, -100, -3, -60, -70, -80, -90, -50, -200, -1000}, 2, -3, 47};
        vecs[3] = '{"extreme", '{-8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192,
                                 8191}, 9, 8191, 16383};
        vecs[4] = '{"allzero", '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 0, 0};
        vecs[5] = '{"first", '{100, 99, -7, 98, 0, 12, 50, 99, -1, 3}, 0, 100, 1};

        repeat (3) @(posedge clk);
        #1;
        check("reset out_idx", int'(out_idx), 0);
        check("reset busy", int'(busy), 0);
        check("reset class_valid", int'(class_valid), 0);
        check("reset class_idx", int'(class_idx), 0);
        check("reset max_score", int'(max_score), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_scan(vecs[i]);

        // dnn_done held high for 30 cycles must produce exactly one scan.
        logits = vecs[0].l;
        @(negedge clk);
        dnn_done = 1'b1;
        busy_cycles = 0; valid_rises = 0; prev_valid = class_valid;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cycles++;
            if (class_valid && !prev_valid) valid_rises++;
            prev_valid = class_valid;
        end
        check("held done busy cycles", busy_cycles, 10);
        check("held done valid rises", valid_rises, 1);
        check("held done result idx", int'(class_idx), 5);
        @(negedge clk);
        dnn_done = 1'b0;
        logits = vecs[2].l;
        sb.push_back('{"rearm", 2, -3, 47});
        @(negedge clk);
        dnn_done = 1'b1;
        @(posedge clk);
        #1;
        check("rearm valid low during scan", int'(class_valid), 0);
        check("rearm busy", int'(busy), 1);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (class_valid) seen = 1'b1;
        end
        check("rearm completes", int'(seen), 1);
        if (sb.size() > 0) compare_result(sb.pop_front());
        @(negedge clk);
        dnn_done = 1'b0;

        // Reset at scan cycle 4 aborts with no valid result afterwards.
        logits = vecs[0].l;
        @(negedge clk);
        dnn_done = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        dnn_done = 1'b0;
        rst = 1'b1;
        #1;
        check("midreset busy", int'(busy), 0);
        check("midreset out_idx", int'(out_idx), 0);
        check("midreset class_valid", int'(class_valid), 0);
        check("midreset class_idx", int'(class_idx), 0);
        check("midreset max_score", int'(max_score), 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (class_valid || busy) seen = 1'b1;
        end
        check("no activity after reset", int'(seen), 0);

        // Clear colliding with a start while in HOLD: clear wins, no scan.
        run_scan(vecs[5]);
        @(negedge clk);
        clear = 1'b1;
        dnn_done = 1'b1;
        @(posedge clk);
        #1;
        check("clear class_valid", int'(class_valid), 0);
        check("clear busy", int'(busy), 0);
        check("clear max_score", int'(max_score), 0);
        clear = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (busy || class_valid) seen = 1'b1;
        end
        check("clear dropped start", int'(seen), 0);
        @(negedge clk);
        dnn_done = 1'b0;
        run_scan(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
